// File: rtl/mux_rr_2to1_pkg.sv
// Shared constants for the 1:2 demux / 2:1 merge pair and their checker:
// default word width, lane indices and the merge FSM state encoding.
package mux_rr_2to1_pkg;

  localparam int DEF_DATA_SIZE = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SEND0 = 2'b01,
    SEND1 = 2'b10
  } state_t;

endpackage

// File: rtl/mux_rr_2to1_arb_rr2.sv
// Two-lane round-robin arbiter: combinational grants from lane occupancy,
// pause and reset, with the last served lane held in a register.
module arb_rr2
  import mux_rr_2to1_pkg::*;
(
  input  logic clk,
  input  logic reset_L,
  input  logic empty0,
  input  logic empty1,
  input  logic pause,
  output logic grant0,
  output logic grant1
);

  logic r_last_sel;
  logic w_req0;
  logic w_req1;

  // reset_L gates the requests so no word is popped while reset is held
  assign w_req0 = reset_L & ~pause & ~empty0;
  assign w_req1 = reset_L & ~pause & ~empty1;

  assign grant0 = w_req0 & (~w_req1 | (r_last_sel == LANE1));
  assign grant1 = w_req1 & (~w_req0 | (r_last_sel == LANE0));

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_last_sel <= LANE1;
    end else if (grant0) begin
      r_last_sel <= LANE0;
    end else if (grant1) begin
      r_last_sel <= LANE1;
    end
  end

endmodule

// File: rtl/mux_rr_2to1.sv
// Merges two first-word-fall-through lane FIFOs into one downstream stream,
// alternating lanes when both hold data so a demuxed stream is reassembled.
//
// state | meaning
// IDLE  | no push this cycle
// SEND0 | pushing a word taken from lane 0
// SEND1 | pushing a word taken from lane 1
module mux_rr_2to1
  import mux_rr_2to1_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic [DATA_SIZE-1:0] data_in0,
  input  logic                 empty0,
  output logic                 pop0,
  input  logic [DATA_SIZE-1:0] data_in1,
  input  logic                 empty1,
  output logic                 pop1,
  input  logic                 pause,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 push
);

  state_t               r_state;
  state_t               w_next_state;
  logic [DATA_SIZE-1:0] r_data_out;
  logic                 w_grant0;
  logic                 w_grant1;

  arb_rr2 u_arb (
    .clk     (clk),
    .reset_L (reset_L),
    .empty0  (empty0),
    .empty1  (empty1),
    .pause   (pause),
    .grant0  (w_grant0),
    .grant1  (w_grant1)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = IDLE;
    if (w_grant0) begin
      w_next_state = SEND0;
    end else if (w_grant1) begin
      w_next_state = SEND1;
    end
  end

  always_comb begin
    pop0 = w_grant0;
    pop1 = w_grant1;
    push = (r_state == SEND0) || (r_state == SEND1);
  end

  // data_out keeps the last pushed word through idle cycles
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data_out <= '0;
    end else if (w_grant0) begin
      r_data_out <= data_in0;
    end else if (w_grant1) begin
      r_data_out <= data_in1;
    end
  end

  assign data_out = r_data_out;

endmodule

// File: tb/tb_mux_rr_2to1.sv
// Bench for mux_rr_2to1: queue-modelled lane FIFOs, a round-robin reference
// that predicts each cycle's grant, and a scoreboard checked by a monitor.
module tb_mux_rr_2to1;

  localparam int W = 4;

  typedef struct {
    bit           valid;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_L = 1'b0;
  logic [W-1:0] data_in0 = '0;
  logic [W-1:0] data_in1 = '0;
  logic         empty0 = 1'b1;
  logic         empty1 = 1'b1;
  logic         pause = 1'b0;
  logic         pop0;
  logic         pop1;
  logic         push;
  logic [W-1:0] data_out;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  exp_t         sb[$];
  logic [W-1:0] out_log[$];
  logic [W-1:0] exp_hold = '0;
  bit           last_lane = 1'b1;

  logic [W-1:0] seq [10] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h3, 4'h4, 4'hA, 4'h9, 4'h7, 4'h8};

  mux_rr_2to1 #(.DATA_SIZE(W)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .data_in0 (data_in0),
    .empty0   (empty0),
    .pop0     (pop0),
    .data_in1 (data_in1),
    .empty1   (empty1),
    .pop1     (pop1),
    .pause    (pause),
    .data_out (data_out),
    .push     (push)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    data_in0 = (q0.size() != 0) ? q0[0] : '0;
    data_in1 = (q1.size() != 0) ? q1[0] : '0;
    empty0   = (q0.size() == 0);
    empty1   = (q1.size() == 0);
  endtask

  // One clock of traffic: predict the grant, check pops, queue the expected push.
  task automatic step(input bit p);
    int g;
    @(negedge clk);
    pause = p;
    drive_inputs();
    #1;
    if (p)                                 g = -1;
    else if (q0.size() != 0 && q1.size() != 0) g = last_lane ? 0 : 1;
    else if (q0.size() != 0)               g = 0;
    else if (q1.size() != 0)               g = 1;
    else                                   g = -1;
    check("pop0", pop0, g == 0);
    check("pop1", pop1, g == 1);
    if (g == 0)      sb.push_back(exp_t'{valid: 1'b1, data: q0[0]});
    else if (g == 1) sb.push_back(exp_t'{valid: 1'b1, data: q1[0]});
    else             sb.push_back(exp_t'{valid: 1'b0, data: '0});
    @(posedge clk);
    #1;
    if (g == 0) begin
      void'(q0.pop_front());
      last_lane = 1'b0;
    end else if (g == 1) begin
      void'(q1.pop_front());
      last_lane = 1'b1;
    end
    drive_inputs();
  endtask

  // Called just after a rising edge; holds reset across one full clock.
  task automatic do_reset();
    reset_L = 1'b0;
    #1;
    check("rst_pop0", pop0, 0);
    check("rst_pop1", pop1, 0);
    check("rst_push", push, 0);
    check("rst_data", data_out, 0);
    sb.delete();
    exp_hold  = '0;
    last_lane = 1'b1;
    @(negedge clk);
    #1;
    check("rst_hold_pop0", pop0, 0);
    check("rst_hold_pop1", pop1, 0);
    @(posedge clk);
    #1;
    check("rst_hold_push", push, 0);
    check("rst_hold_data", data_out, 0);
    reset_L = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_L) begin
        if (sb.size() == 0) begin
          check("idle_push", push, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("push", push, e.valid);
          if (e.valid) begin
            check("data_out", data_out, e.data);
            exp_hold = e.data;
            out_log.push_back(data_out);
          end else begin
            check("data_hold", data_out, exp_hold);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // reset with both lanes holding data, then interleaved drain
    q0 = '{4'hF, 4'hD};
    q1 = '{4'hE, 4'hC};
    drive_inputs();
    #2;
    check("init_pop0", pop0, 0);
    check("init_pop1", pop1, 0);
    check("init_push", push, 0);
    check("init_data", data_out, 0);
    @(posedge clk);
    #1;
    do_reset();
    repeat (6) step(1'b0);

    // single lane, then both lanes fill
    q1 = '{4'hA, 4'h9};
    repeat (2) step(1'b0);
    q0.push_back(4'h3);
    q1.push_back(4'h4);
    repeat (4) step(1'b0);

    // pause with both lanes ready
    q0 = '{4'h1, 4'h2};
    q1 = '{4'h5, 4'h6};
    step(1'b0);
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);

    // reset mid-stream after 7 was taken
    q0 = '{4'h7, 4'h8};
    step(1'b0);
    step(1'b1);
    do_reset();
    q1.push_back(4'hC);
    repeat (4) step(1'b0);

    // loopback of a demux-split sequence
    @(posedge clk);
    #1;
    do_reset();
    out_log.delete();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) q0.push_back(seq[i]);
      else            q1.push_back(seq[i]);
    end
    repeat (12) step(1'b0);
    check("loop_len", out_log.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("loop_%0d", i), (i < out_log.size()) ? out_log[i] : 'x, seq[i]);
    end

    // randomized traffic with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      if (q0.size() < 4 && $urandom_range(1, 0) == 1) q0.push_back(W'($urandom));
      if (q1.size() < 4 && $urandom_range(1, 0) == 1) q1.push_back(W'($urandom));
      step($urandom_range(4, 0) == 0);
      if (c == 200) do_reset();
    end
    for (int c = 0; c < 20 && (q0.size() != 0 || q1.size() != 0); c++) step(1'b0);
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);
    repeat (3) step(1'b0);
    @(negedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
